// File: rtl/isa_io_cycle.sv
// rtl/isa_io_cycle.sv - ISA I/O bus-cycle engine: setup, IOR#/IOW# strobe with IOCHRDY waits and timeout, hold
//
// Ports:
//   bus_clock, reset          clock (rising edge) and asynchronous active-high reset
//   req_valid/req_ready       request handshake; transfer on valid & ready
//   req_write                 1 = I/O write, 0 = I/O read
//   req_address, req_data     port address and write data
//   resp_valid                one-cycle completion pulse
//   resp_data, resp_timeout   read data (held until the next read ends) and timeout flag
//   busy                      high whenever a cycle is in progress
//   isa_address               A pins
//   isa_data_out, isa_data_oe D pins and their output enable (writes only)
//   isa_data_in               D pins as seen by this block
//   isa_ior_n, isa_iow_n      active-low I/O strobes
//   isa_aen                   AEN, low while a cycle owns the bus
//   isa_iochrdy               IOCHRDY from the card, low requests wait states

module isa_io_cycle #(
    parameter int ADDR_SETUP_CLKS = 1,
    parameter int STROBE_CLKS     = 4,
    parameter int HOLD_CLKS       = 1,
    parameter int TIMEOUT_CLKS    = 64
) (
    input  logic        bus_clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_address,
    input  logic [15:0] req_data,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic        resp_timeout,
    output logic        busy,
    output logic [15:0] isa_address,
    output logic [15:0] isa_data_out,
    output logic        isa_data_oe,
    input  logic [15:0] isa_data_in,
    output logic        isa_ior_n,
    output logic        isa_iow_n,
    output logic        isa_aen,
    input  logic        isa_iochrdy
);

    localparam logic [7:0] SETUP_LOAD  = 8'(ADDR_SETUP_CLKS - 1);
    localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CLKS - 1);
    localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CLKS - 1);
    localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [7:0]  tmo;
    logic        wr_q;
    logic        tmo_flag;
    logic [15:0] rd_q;
    logic        rdy_m;
    logic        rdy_s;
    logic        strobe_tmo;
    logic        strobe_exit;

    // IOCHRDY is asynchronous to bus_clock; reset to "ready" so a card that
    // never drives the line cannot stall the first cycle after reset.
    always_ff @(posedge bus_clock or posedge reset) begin
        if (reset) begin
            rdy_m <= 1'b1;
            rdy_s <= 1'b1;
        end else begin
            rdy_m <= isa_iochrdy;
            rdy_s <= rdy_m;
        end
    end

    // Timeout is checked independently of the minimum-width counter so it
    // takes precedence when both conditions land on the same cycle.
    assign strobe_tmo  = (tmo == TMO_LAST);
    assign strobe_exit = strobe_tmo || ((cnt == 8'd0) && rdy_s);

    assign req_ready = (state == S_IDLE) && !reset;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge bus_clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= 8'd0;
            tmo          <= 8'd0;
            wr_q         <= 1'b0;
            tmo_flag     <= 1'b0;
            rd_q         <= 16'd0;
            isa_ior_n    <= 1'b1;
            isa_iow_n    <= 1'b1;
            isa_data_oe  <= 1'b0;
            isa_aen      <= 1'b1;
            isa_address  <= 16'd0;
            isa_data_out <= 16'd0;
            resp_valid   <= 1'b0;
            resp_data    <= 16'd0;
            resp_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    resp_valid   <= 1'b0;
                    resp_timeout <= 1'b0;
                    if (req_valid) begin
                        wr_q        <= req_write;
                        isa_address <= req_address;
                        if (req_write) begin
                            isa_data_out <= req_data;
                            isa_data_oe  <= 1'b1;
                        end
                        isa_aen <= 1'b0;
                        cnt     <= SETUP_LOAD;
                        state   <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (cnt == 8'd0) begin
                        if (wr_q) begin
                            isa_iow_n <= 1'b0;
                        end else begin
                            isa_ior_n <= 1'b0;
                        end
                        cnt   <= STROBE_LOAD;
                        tmo   <= 8'd0;
                        state <= S_STROBE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                S_STROBE: begin
                    if (strobe_exit) begin
                        isa_ior_n <= 1'b1;
                        isa_iow_n <= 1'b1;
                        if (!wr_q) begin
                            rd_q <= isa_data_in;
                        end
                        tmo_flag <= strobe_tmo;
                        cnt      <= HOLD_LOAD;
                        state    <= S_HOLD;
                    end else begin
                        tmo <= tmo + 8'd1;
                        // Minimum width elapsed: keep waiting on IOCHRDY at zero.
                        if (cnt != 8'd0) begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end

                S_HOLD: begin
                    if (cnt == 8'd0) begin
                        resp_valid   <= 1'b1;
                        resp_timeout <= tmo_flag;
                        if (!wr_q) begin
                            resp_data <= rd_q;
                        end
                        // Bus is handed back as the completion pulse goes out.
                        isa_data_oe <= 1'b0;
                        isa_aen     <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                S_DONE: begin
                    resp_valid   <= 1'b0;
                    resp_timeout <= 1'b0;
                    state        <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
